bk_subtractor_pipe: RTL and testbench

Pipelined 16-bit Brent-Kung subtractor computing `diff = a - b - bin`, with valid/ready handshakes on both sides. It is the inverse-operation companion of the team's combinational Brent-Kung adder and reuses the same generate/propagate prefix network. The tree is split across two register stages, giving one result per cycle at 2-cycle latency with full backpressure support. It sits between operand-producing logic and any downstream consumer that may stall.

---
 rtl/bk_subtractor_pipe_pkg.sv | 12 +
 rtl/bk_subtractor_pipe_gp_cell.sv | 13 +
 rtl/bk_subtractor_pipe.sv | 161 ++++++++++++++++
 tb/tb_bk_subtractor_pipe.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bk_subtractor_pipe_pkg.sv
// Shared types and sizing for the Brent-Kung subtractor pipeline.
package bk_pkg;

  localparam int BK_WIDTH  = 16;
  localparam int BK_LEVELS = $clog2(BK_WIDTH);

  typedef struct packed {
    logic g;
    logic p;
  } gp_t;

endpackage

// File: rtl/bk_subtractor_pipe_gp_cell.sv
// Group generate/propagate combine cell; tie lo.p to 0 for the carry-apply form.
module bk_gp_cell
  import bk_pkg::*;
(
  input  gp_t hi,
  input  gp_t lo,
  output gp_t gp
);

  assign gp.g = hi.g | (hi.p & lo.g);
  assign gp.p = hi.p & lo.p;

endmodule

// File: rtl/bk_subtractor_pipe.sv
// Two-stage Brent-Kung subtractor (a - b - bin) with valid/ready on both sides.
module bk_subtractor_pipe
  import bk_pkg::*;
#(
  parameter int WIDTH = BK_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             zero,
  output logic             ovf
);

  localparam int LEVELS = $clog2(WIDTH);

  logic s1_valid, s2_valid, s1_adv, s2_adv;

  assign s2_adv    = !s2_valid || out_ready;
  assign s1_adv    = !s1_valid || s2_adv;
  assign in_ready  = s1_adv;
  assign out_valid = s2_valid;

  // Stage 1: bit terms, carry-in folded into bit 0, pair and quad groups.
  logic             cin;
  logic [WIDTH-1:0] bit_p, bit_g;
  gp_t              s1_l0 [WIDTH];
  gp_t              s1_l1 [WIDTH];
  gp_t              s1_l2 [WIDTH];

  assign cin   = ~bin;
  assign bit_p = a ^ ~b;
  assign bit_g = a & ~b;

  genvar gi, gj;
  for (gi = 0; gi < WIDTH; gi++) begin : g_s1
    if (gi == 0) begin : g_leaf0
      assign s1_l0[gi] = {bit_g[0] | (bit_p[0] & cin), bit_p[0]};
    end else begin : g_leaf
      assign s1_l0[gi] = {bit_g[gi], bit_p[gi]};
    end
    if (gi % 2 == 1) begin : g_pair
      bk_gp_cell u_cell (.hi(s1_l0[gi]), .lo(s1_l0[gi-1]), .gp(s1_l1[gi]));
    end else begin : g_pair_pass
      assign s1_l1[gi] = s1_l0[gi];
    end
    if (gi % 4 == 3) begin : g_quad
      bk_gp_cell u_cell (.hi(s1_l1[gi]), .lo(s1_l1[gi-2]), .gp(s1_l2[gi]));
    end else begin : g_quad_pass
      assign s1_l2[gi] = s1_l1[gi];
    end
  end

  logic [WIDTH-1:0] s1_p;
  gp_t              s1_grp [WIDTH];
  logic             s1_cin, s1_a_msb, s1_b_msb;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
    end else if (s1_adv) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_p     <= bit_p;
        s1_grp   <= s1_l2;
        s1_cin   <= cin;
        s1_a_msb <= a[WIDTH-1];
        s1_b_msb <= b[WIDTH-1];
      end
    end
  end

  // Stage 2 up-sweep: groups of 8, 16, ... ending at the top of each span.
  for (gi = 2; gi <= LEVELS; gi++) begin : g_up
    gp_t node [WIDTH];
    for (gj = 0; gj < WIDTH; gj++) begin : g_col
      if (gi == 2) begin : g_src
        assign node[gj] = s1_grp[gj];
      end else if (gj % (1 << gi) == (1 << gi) - 1) begin : g_cell
        bk_gp_cell u_cell (
          .hi(g_up[gi-1].node[gj]),
          .lo(g_up[gi-1].node[gj - (1 << (gi - 1))]),
          .gp(node[gj])
        );
      end else begin : g_pass
        assign node[gj] = g_up[gi-1].node[gj];
      end
    end
  end

  // Down-sweep: each mid-span column picks up the finished prefix below it.
  for (gi = 0; gi < LEVELS - 1; gi++) begin : g_dn
    localparam int LVL  = LEVELS - 1 - gi;
    localparam int STEP = 1 << (LVL - 1);
    localparam int SPAN = 1 << LVL;
    gp_t src  [WIDTH];
    gp_t node [WIDTH];
    if (gi == 0) begin : g_first
      assign src = g_up[LEVELS].node;
    end else begin : g_next
      assign src = g_dn[gi-1].node;
    end
    for (gj = 0; gj < WIDTH; gj++) begin : g_col
      if ((gj % SPAN) == STEP - 1 && gj >= SPAN) begin : g_cell
        gp_t lo_carry;
        assign lo_carry = {src[gj-STEP].g, 1'b0};
        bk_gp_cell u_cell (.hi(src[gj]), .lo(lo_carry), .gp(node[gj]));
      end else begin : g_pass
        assign node[gj] = src[gj];
      end
    end
  end

  gp_t              fin [WIDTH];
  logic [WIDTH-1:0] carry, fin_p, diff_next;
  logic             bout_next, zero_next, ovf_next, unused_p;

  assign fin = g_dn[LEVELS-2].node;

  for (gi = 0; gi < WIDTH; gi++) begin : g_carry
    assign fin_p[gi] = fin[gi].p;
    if (gi == 0) begin : g_c0
      assign carry[gi] = s1_cin;
    end else begin : g_ci
      assign carry[gi] = fin[gi-1].g;
    end
  end

  // Prefix propagate terms are not needed once every carry includes carry-in.
  assign unused_p  = ^fin_p;
  assign diff_next = s1_p ^ carry;
  assign bout_next = ~fin[WIDTH-1].g;
  assign zero_next = (diff_next == '0);
  assign ovf_next  = (s1_a_msb != s1_b_msb) && (diff_next[WIDTH-1] != s1_a_msb);

  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid <= 1'b0;
      diff     <= '0;
      bout     <= 1'b0;
      zero     <= 1'b0;
      ovf      <= 1'b0;
    end else if (s2_adv) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        diff <= diff_next;
        bout <= bout_next;
        zero <= zero_next;
        ovf  <= ovf_next;
      end
    end
  end

endmodule

// File: tb/tb_bk_subtractor_pipe.sv
// Scoreboard bench for bk_subtractor_pipe: arithmetic, latency, backpressure, reset.
module tb_bk_subtractor_pipe;

  localparam int W = 16;

  logic         clk, rst, in_valid, in_ready, bin, out_valid, out_ready;
  logic         bout, zero, ovf;
  logic [W-1:0] a, b, diff;

  int n_cmp = 0;
  int n_err = 0;

  // Entry layout: {diff, bout, zero, ovf}.
  logic [W+2:0] sb [$];

  logic [W-1:0] va [5] = '{16'h0005, 16'h0000, 16'h8000, 16'h7FFF, 16'h1234};
  logic [W-1:0] vb [5] = '{16'h0003, 16'h0001, 16'h0001, 16'hFFFF, 16'h1233};
  logic         vc [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
  logic [W+2:0] vx [5] = '{{16'h0002, 3'b000}, {16'hFFFF, 3'b100}, {16'h7FFF, 3'b001},
                           {16'h8000, 3'b101}, {16'h0000, 3'b010}};

  bk_subtractor_pipe #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .bin(bin), .out_valid(out_valid), .out_ready(out_ready),
    .diff(diff), .bout(bout), .zero(zero), .ovf(ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [W+2:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                         input logic mc);
    logic [W:0]   full;
    logic [W-1:0] d;
    logic         o;
    full = {1'b0, ma} - {1'b0, mb} - {{W{1'b0}}, mc};
    d    = full[W-1:0];
    o    = (ma[W-1] != mb[W-1]) && (d[W-1] != ma[W-1]);
    return {d, full[W], (d == '0), o};
  endfunction

  // Inputs change just after posedge, so the negedge sees what the next edge will see.
  always @(negedge clk) begin
    logic [W+2:0] exp_v;
    if (rst) begin
      sb.delete();
    end else begin
      if (out_valid && out_ready) begin
        n_cmp++;
        if (sb.size() == 0) begin
          n_err++;
          $display("FAIL sb_underflow: got diff=%h with no beat outstanding", diff);
        end else begin
          exp_v = sb.pop_front();
          if ({diff, bout, zero, ovf} !== exp_v)
            begin
              n_err++;
              $display("FAIL sb_result: got diff=%h bout=%b zero=%b ovf=%b, want diff=%h bout=%b zero=%b ovf=%b",
                       diff, bout, zero, ovf, exp_v[W+2:3], exp_v[2], exp_v[1], exp_v[0]);
            end
          else
            $display("ok   sb_result: diff=%h bout=%b zero=%b ovf=%b", diff, bout, zero, ovf);
        end
      end
      if (in_valid && in_ready) sb.push_back(model(a, b, bin));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int t = 0; t < 20; t++) begin
      if (sb.size() == 0 && !out_valid) break;
      tick();
    end
    n_cmp++;
    if (sb.size() != 0 || out_valid) begin
      n_err++;
      $display("FAIL drain: got %0d beats outstanding out_valid=%b, want 0 and 0", sb.size(), out_valid);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b1; a = 16'h00FF; b = 16'h0001; bin = 1'b0; out_ready = 1'b1;
    repeat (3) tick();
    rst = 1'b0; in_valid = 1'b0;
    #1;
    n_cmp++;
    if ({out_valid, diff, bout, zero, ovf} !== {1'b0, {W{1'b0}}, 3'b000}) begin
      n_err++;
      $display("FAIL reset_state: got valid=%b diff=%h bout=%b zero=%b ovf=%b, want all 0",
               out_valid, diff, bout, zero, ovf);
    end
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL reset_in_ready: got %b want 1", in_ready);
    end
    tick();
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL no_accept_in_rst: got out_valid=%b want 0", out_valid);
    end
  endtask

  task automatic test_vectors();
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      a = va[i]; b = vb[i]; bin = vc[i]; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      n_cmp++;
      if (out_valid !== 1'b0) begin
        n_err++;
        $display("FAIL latency_early vec%0d: got out_valid=%b want 0", i, out_valid);
      end
      tick();
      n_cmp++;
      if ({out_valid, diff, bout, zero, ovf} !== {1'b1, vx[i]}) begin
        n_err++;
        $display("FAIL vector%0d: got valid=%b diff=%h bout=%b zero=%b ovf=%b, want valid=1 diff=%h bout=%b zero=%b ovf=%b",
                 i, out_valid, diff, bout, zero, ovf, vx[i][W+2:3], vx[i][2], vx[i][1], vx[i][0]);
      end
    end
    drain();
  endtask

  task automatic test_backpressure();
    logic [W-1:0] ba [6];
    logic [W-1:0] bb [6];
    logic [W+3:0] held;
    logic         acc;
    int           k;
    for (int i = 0; i < 6; i++) begin
      ba[i] = W'($urandom);
      bb[i] = W'($urandom);
    end
    k = 0; held = '0;
    out_ready = 1'b0;
    for (int cyc = 0; cyc < 6; cyc++) begin
      a = ba[k]; b = bb[k]; bin = k[0]; in_valid = (k < 6);
      #1;
      if (cyc == 2) begin
        n_cmp++;
        if (in_ready !== 1'b0) begin
          n_err++;
          $display("FAIL bp_full: got in_ready=%b want 0 after 2 beats", in_ready);
        end
        held = {out_valid, diff, bout, zero, ovf};
      end
      if (cyc >= 3) begin
        n_cmp++;
        if ({out_valid, diff, bout, zero, ovf} !== held || out_valid !== 1'b1) begin
          n_err++;
          $display("FAIL bp_stable cyc%0d: got %h want %h (valid high)", cyc,
                   {out_valid, diff, bout, zero, ovf}, held);
        end
      end
      acc = in_valid && in_ready;
      tick();
      if (acc) k++;
    end
    out_ready = 1'b1;
    for (int t = 0; t < 40 && k < 6; t++) begin
      a = ba[k]; b = bb[k]; bin = k[0]; in_valid = 1'b1;
      #1;
      acc = in_ready;
      tick();
      if (acc) k++;
    end
    n_cmp++;
    if (k != 6) begin
      n_err++;
      $display("FAIL bp_accept_all: got %0d beats accepted want 6", k);
    end
    drain();
  endtask

  task automatic test_back_to_back();
    int acc_n;
    out_ready = 1'b1;
    for (int i = 0; i < 24; i++) begin
      a = W'($urandom); b = W'($urandom); bin = 1'($urandom); in_valid = 1'b1;
      if (i == 5) begin a = 16'h0000; b = 16'h0001; bin = 1'b0; end
      #1;
      n_cmp++;
      if (in_ready !== 1'b1) begin
        n_err++;
        $display("FAIL b2b_ready beat%0d: got in_ready=%b want 1", i, in_ready);
      end
      tick();
    end
    drain();
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      a = W'($urandom); b = W'($urandom); bin = 1'b0; in_valid = 1'b1;
      tick();
    end
    #1;
    n_cmp++;
    if (in_ready !== 1'b0) begin
      n_err++;
      $display("FAIL full_stall: got in_ready=%b want 0", in_ready);
    end
    out_ready = 1'b1;
    #1;
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL full_push_pop: got in_ready=%b want 1", in_ready);
    end
    acc_n = 0;
    for (int i = 0; i < 4; i++) begin
      a = W'($urandom); b = W'($urandom); bin = 1'b1; in_valid = 1'b1;
      #1;
      if (in_ready) acc_n++;
      tick();
    end
    n_cmp++;
    if (acc_n != 4) begin
      n_err++;
      $display("FAIL full_throughput: got %0d accepts want 4", acc_n);
    end
    drain();
  endtask

  task automatic test_reset_midflight();
    bit seen;
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      a = 16'h4000 + W'(i); b = 16'h0100; bin = 1'b0; in_valid = 1'b1;
      tick();
    end
    #1;
    n_cmp++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
      n_err++;
      $display("FAIL mid_full: got out_valid=%b in_ready=%b want 1 and 0", out_valid, in_ready);
    end
    rst = 1'b1; in_valid = 1'b0;
    tick();
    rst = 1'b0;
    #1;
    n_cmp++;
    if ({out_valid, diff, bout, zero, ovf} !== {1'b0, {W{1'b0}}, 3'b000} || in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL mid_reset: got valid=%b diff=%h bout=%b zero=%b ovf=%b in_ready=%b, want zeros and in_ready=1",
               out_valid, diff, bout, zero, ovf, in_ready);
    end
    a = 16'h00A0; b = 16'h0005; bin = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    seen = 1'b0;
    for (int t = 0; t < 10 && !seen; t++) begin
      if (out_valid) seen = 1'b1;
      else tick();
    end
    n_cmp++;
    if (!seen || diff !== 16'h009A) begin
      n_err++;
      $display("FAIL mid_first_out: got seen=%b diff=%h want seen=1 diff=009a", seen, diff);
    end
    drain();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_vectors();
    test_backpressure();
    test_back_to_back();
    test_reset_midflight();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
